// File: rtl/atn_spi_pkg.sv
// Shared types and constants for the attenuator/DAC SPI slave.
package atn_spi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    LOCKOUT = 2'd2
  } spi_state_e;

  // SPI modes encoded as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DEF_D_WIDTH = 32'd8;

  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic mode_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronises sclk, ss_n and mosi into the system clock domain and
// derives ss_n and sclk leading/trailing edge strobes.
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = 1'b0
) (
  input  logic clock,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  output logic ss_sync,
  output logic ss_fall,
  output logic ss_rise,
  output logic lead_edge,
  output logic trail_edge,
  output logic mosi_sync
);

  logic [SYNC_STAGES-1:0] sclk_pipe_r;
  logic [SYNC_STAGES-1:0] ss_pipe_r;
  logic [SYNC_STAGES-1:0] mosi_pipe_r;
  logic                   sclk_d_r;
  logic                   ss_d_r;
  logic                   sclk_s;

  // Synchroniser chains plus one delayed copy for edge detect; deliberately
  // not reset so the true ss_n level is visible while reset is asserted.
  always_ff @(posedge clock) begin
    sclk_pipe_r <= {sclk_pipe_r[SYNC_STAGES-2:0], sclk};
    ss_pipe_r   <= {ss_pipe_r[SYNC_STAGES-2:0], ss_n};
    mosi_pipe_r <= {mosi_pipe_r[SYNC_STAGES-2:0], mosi};
    sclk_d_r    <= sclk_pipe_r[SYNC_STAGES-1];
    ss_d_r      <= ss_pipe_r[SYNC_STAGES-1];
  end

  assign sclk_s     = sclk_pipe_r[SYNC_STAGES-1];
  assign ss_sync    = ss_pipe_r[SYNC_STAGES-1];
  assign mosi_sync  = mosi_pipe_r[SYNC_STAGES-1];
  assign ss_fall    = ss_d_r & ~ss_sync;
  assign ss_rise    = ~ss_d_r & ss_sync;
  assign lead_edge  = (sclk_s != sclk_d_r) && (sclk_d_r == CPOL);
  assign trail_edge = (sclk_s != sclk_d_r) && (sclk_s == CPOL);

endmodule

// File: rtl/atn_spi_slave.sv
// SPI slave for the attenuator/DAC write link: oversampled receive of
// MSB-first words with a readback word shifted out on miso.
module atn_spi_slave
  import atn_spi_pkg::*;
#(
  parameter int D_WIDTH     = DEF_D_WIDTH,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sclk,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  input  logic [D_WIDTH-1:0] tx_data,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               busy
);

  localparam int CW = $clog2(D_WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(D_WIDTH);

  spi_state_e         state_r, state_n;
  logic [CW-1:0]      bit_cnt_r, bit_cnt_n;
  logic [D_WIDTH-1:0] rx_shift_r, rx_shift_n;
  logic [D_WIDTH-1:0] tx_shift_r, tx_shift_n;
  logic [D_WIDTH-1:0] rx_data_r, rx_data_n;
  logic               shift_en_r, shift_en_n;
  logic               show_r, show_n;
  logic               rx_valid_r, rx_valid_n;
  logic               frame_err_r, frame_err_n;
  logic               miso_r, miso_n;
  logic               busy_r, busy_n;
  logic               ss_sync_s, ss_fall_s, ss_rise_s, lead_s, trail_s, mosi_s;
  logic               sample_s, shift_s, word_done_s;

  spi_slave_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .CPOL       (CPOL)
  ) u_sync (
    .clock     (clock),
    .sclk      (sclk),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .ss_sync   (ss_sync_s),
    .ss_fall   (ss_fall_s),
    .ss_rise   (ss_rise_s),
    .lead_edge (lead_s),
    .trail_edge(trail_s),
    .mosi_sync (mosi_s)
  );

  assign sample_s    = CPHA ? trail_s : lead_s;
  assign shift_s     = CPHA ? lead_s : trail_s;
  assign word_done_s = (bit_cnt_r == CNT_FULL);

  // Next-state and datapath decode. shift_en gates tx shifting until the
  // current word has seen a sample edge, so the edge following a reload
  // presents the new MSB instead of discarding it.
  always_comb begin
    state_n     = state_r;
    bit_cnt_n   = bit_cnt_r;
    rx_shift_n  = rx_shift_r;
    tx_shift_n  = tx_shift_r;
    rx_data_n   = rx_data_r;
    shift_en_n  = shift_en_r;
    show_n      = show_r;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
    case (state_r)
      IDLE: begin
        if (ss_fall_s) begin
          state_n    = ACTIVE;
          bit_cnt_n  = CNT_ZERO;
          rx_shift_n = '0;
          tx_shift_n = tx_data;
          shift_en_n = 1'b0;
          show_n     = ~CPHA;
        end else begin
          state_n = IDLE;
        end
      end
      ACTIVE: begin
        if (word_done_s) begin
          rx_data_n  = rx_shift_r;
          rx_valid_n = 1'b1;
          bit_cnt_n  = CNT_ZERO;
          tx_shift_n = tx_data;
          shift_en_n = 1'b0;
        end else begin
          rx_valid_n = 1'b0;
        end
        if (ss_rise_s) begin
          state_n     = IDLE;
          show_n      = 1'b0;
          frame_err_n = ~word_done_s && (bit_cnt_r != CNT_ZERO);
        end else if (sample_s) begin
          rx_shift_n = {rx_shift_r[D_WIDTH-2:0], mosi_s};
          bit_cnt_n  = word_done_s ? CNT_ONE : bit_cnt_r + CNT_ONE;
          shift_en_n = 1'b1;
        end else if (shift_s) begin
          show_n = 1'b1;
          if (shift_en_r && !word_done_s) begin
            tx_shift_n = {tx_shift_r[D_WIDTH-2:0], 1'b0};
          end else begin
            shift_en_n = shift_en_n & ~word_done_s;
          end
        end else begin
          state_n = ACTIVE;
        end
      end
      LOCKOUT: begin
        if (ss_sync_s) begin
          state_n = IDLE;
        end else begin
          state_n = LOCKOUT;
        end
      end
      default: begin
        state_n = LOCKOUT;
      end
    endcase
    busy_n = (state_n == ACTIVE);
    miso_n = busy_n & show_n & tx_shift_n[D_WIDTH-1];
  end

  // State and output registers; reset parks in LOCKOUT if a frame is in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ss_sync_s ? IDLE : LOCKOUT;
      bit_cnt_r   <= CNT_ZERO;
      rx_shift_r  <= '0;
      tx_shift_r  <= '0;
      rx_data_r   <= '0;
      shift_en_r  <= 1'b0;
      show_r      <= 1'b0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      miso_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      bit_cnt_r   <= bit_cnt_n;
      rx_shift_r  <= rx_shift_n;
      tx_shift_r  <= tx_shift_n;
      rx_data_r   <= rx_data_n;
      shift_en_r  <= shift_en_n;
      show_r      <= show_n;
      rx_valid_r  <= rx_valid_n;
      frame_err_r <= frame_err_n;
      miso_r      <= miso_n;
      busy_r      <= busy_n;
    end
  end

  assign miso      = miso_r;
  assign miso_oe   = busy_r;
  assign busy      = busy_r;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;

endmodule
